// File: rtl/rrv_gpr_trk_fifo.sv
// rrv_gpr_trk_fifo: GPR write-back tracker, snoops write-back channels
// and queues {stamp, channel, rd, data} entries for a valid/ready drainer.
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   trk_en              logging enable (shadow file updates regardless)
//   wb_valid/rd/data    NUM_WB packed write-back channels (channel 0 in LSBs)
//   trk_valid/ready     head handshake; trk_stamp/chan/rd/data are head fields
//   trk_count           FIFO occupancy
//   drop_cnt/drop_clr   saturating count of writes lost to a full FIFO, clear
module rrv_gpr_trk_fifo #(
    parameter int NUM_WB = 1,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    parameter int MODE   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       trk_en,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [5*NUM_WB-1:0]        wb_rd,
    input  logic [DATA_W*NUM_WB-1:0]   wb_data,
    output logic                       trk_valid,
    input  logic                       trk_ready,
    output logic [TS_W-1:0]            trk_stamp,
    output logic [1:0]                 trk_chan,
    output logic [4:0]                 trk_rd,
    output logic [DATA_W-1:0]          trk_data,
    output logic [$clog2(DEPTH):0]     trk_count,
    output logic [15:0]                drop_cnt,
    input  logic                       drop_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [TS_W-1:0]   stamp;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    logic [TS_W-1:0]   m_stamp [DEPTH];
    logic [1:0]        m_chan  [DEPTH];
    logic [4:0]        m_rd    [DEPTH];
    logic [DATA_W-1:0] m_data  [DEPTH];
    logic [DATA_W-1:0] shadow  [32];

    logic [NUM_WB-1:0] qual;
    logic [PW-1:0]     off [NUM_WB];
    logic [CW-1:0]     q_num;
    logic [CW-1:0]     free;
    logic [CW-1:0]     pushed;
    logic              push_ok;
    logic              pop;
    logic [16:0]       drop_sum;

    // Qualify every channel against the start-of-cycle shadow and give
    // each qualifying write its slot offset in ascending channel order.
    always_comb begin
        q_num = '0;
        qual  = '0;
        for (int c = 0; c < NUM_WB; c++) begin
            qual[c] = wb_valid[c] && (wb_rd[c*5 +: 5] != 5'd0) && trk_en &&
                      (MODE == 0 ||
                       wb_data[c*DATA_W +: DATA_W] != shadow[wb_rd[c*5 +: 5]]);
            off[c]  = q_num[PW-1:0];
            q_num   = q_num + CW'(qual[c]);
        end
    end

    // Space is judged on the pre-pop occupancy and all-or-nothing per cycle.
    assign free     = CW'(DEPTH) - trk_count;
    assign push_ok  = (q_num <= free);
    assign pushed   = push_ok ? q_num : '0;
    assign pop      = trk_valid & trk_ready;
    assign drop_sum = {1'b0, drop_cnt} + 17'(q_num);

    assign trk_valid = (trk_count != '0);
    assign trk_stamp = m_stamp[rd_ptr];
    assign trk_chan  = m_chan[rd_ptr];
    assign trk_rd    = m_rd[rd_ptr];
    assign trk_data  = m_data[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stamp     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            trk_count <= '0;
            drop_cnt  <= '0;
        end else begin
            stamp     <= stamp + 1'b1;
            wr_ptr    <= wr_ptr + PW'(pushed);
            rd_ptr    <= rd_ptr + PW'(pop);
            trk_count <= trk_count + pushed - CW'(pop);
            if (drop_clr)
                drop_cnt <= '0;
            else if (!push_ok)
                drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_stamp[i] <= '0;
                m_chan[i]  <= '0;
                m_rd[i]    <= '0;
                m_data[i]  <= '0;
            end
        end else if (push_ok) begin
            for (int c = 0; c < NUM_WB; c++) begin
                if (qual[c]) begin
                    m_stamp[wr_ptr + off[c]] <= stamp;
                    m_chan[wr_ptr + off[c]]  <= 2'(c);
                    m_rd[wr_ptr + off[c]]    <= wb_rd[c*5 +: 5];
                    m_data[wr_ptr + off[c]]  <= wb_data[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Later channels overwrite earlier ones, so the highest channel wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++)
                shadow[r] <= '0;
        end else begin
            for (int c = 0; c < NUM_WB; c++) begin
                if (wb_valid[c] && wb_rd[c*5 +: 5] != 5'd0)
                    shadow[wb_rd[c*5 +: 5]] <= wb_data[c*DATA_W +: DATA_W];
            end
        end
    end

endmodule
